// File: rtl/reshape_pkg.sv
// reshape_pkg: shared bank state type and sizing helpers for reshape_serializer.
package reshape_pkg;
  typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e;
  function automatic int beats(input int n_in, input int lanes);
    return n_in / lanes;
  endfunction
  function automatic int cnt_w(input int n_beats);
    return n_beats > 1 ? $clog2(n_beats) : 1;
  endfunction
endpackage

// File: rtl/reshape_bank.sv
// reshape_bank: one frame register with parallel load and lane-indexed beat read.
module reshape_bank
  import reshape_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_IN = 40,
  parameter int LANES = 1,
  localparam int CW = cnt_w(beats(N_IN, LANES))
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load,
  input  logic [N_IN-1:0][DATA_W-1:0]  d,
  input  logic [CW-1:0]                idx,
  output logic [LANES-1:0][DATA_W-1:0] beat
);
  logic [N_IN-1:0][DATA_W-1:0] frame_q, frame_d;
  always_comb frame_d = load ? d : frame_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) frame_q <= '0;
    else frame_q <= frame_d;
  assign beat = frame_q[int'(idx)*LANES +: LANES];
endmodule

// File: rtl/reshape_serializer.sv
// reshape_serializer: captures an N_IN-word frame and streams it out LANES words per beat.
// Define RESHAPE_SER_PINGPONG_EN to add a shadow bank that loads while the active bank drains.
module reshape_serializer
  import reshape_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_IN = 40,
  parameter int LANES = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_IN-1:0][DATA_W-1:0]  in,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [LANES-1:0][DATA_W-1:0] out,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last
);
  localparam int BEATS = beats(N_IN, LANES);
  localparam int CW = cnt_w(BEATS);
  if (N_IN < 2 || N_IN % LANES != 0) begin : g_bad_cfg
    $error("reshape_serializer: N_IN must be >= 2 and a multiple of LANES");
  end
  bank_state_e act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last, in_xfer, out_xfer, ld_act;
  assign last = cnt_q == CW'(BEATS - 1);
  assign m_valid = act_q == BANK_FULL;
  assign m_last = m_valid & last;
  assign in_xfer = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;
  // A new frame goes straight to the active bank when it is idle or just emptied.
  assign ld_act = in_xfer & (!m_valid | (out_xfer & last));
`ifdef RESHAPE_SER_PINGPONG_EN
  bank_state_e shd_q, shd_d;
  logic sel_q, sel_d, s_ready_q, s_ready_d, ld_shd;
  logic [1:0][LANES-1:0][DATA_W-1:0] beat;
  assign ld_shd = in_xfer & !ld_act;
  assign s_ready = s_ready_q;
  assign out = beat[sel_q];
  for (genvar g = 0; g < 2; g++) begin : g_bank
    reshape_bank #(.DATA_W(DATA_W), .N_IN(N_IN), .LANES(LANES)) u_bank (
      .clk(clk), .reset_n(reset_n), .load(sel_q == 1'(g) ? ld_act : ld_shd),
      .d(in), .idx(cnt_q), .beat(beat[g])
    );
  end
`else
  assign s_ready = !m_valid | (m_ready & m_last);
  reshape_bank #(.DATA_W(DATA_W), .N_IN(N_IN), .LANES(LANES)) u_bank (
    .clk(clk), .reset_n(reset_n), .load(ld_act), .d(in), .idx(cnt_q), .beat(out)
  );
`endif
  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    if (out_xfer) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      act_d = last ? BANK_EMPTY : BANK_FULL;
    end
    if (ld_act) begin
      act_d = BANK_FULL;
      cnt_d = '0;
    end
`ifdef RESHAPE_SER_PINGPONG_EN
    sel_d = sel_q;
    shd_d = shd_q;
    // Promotion is a bank-select flip, so the shadow frame is never copied.
    if (out_xfer && last && shd_q == BANK_FULL) begin
      sel_d = !sel_q;
      act_d = BANK_FULL;
      shd_d = BANK_EMPTY;
    end
    if (ld_shd) shd_d = BANK_FULL;
    s_ready_d = shd_d == BANK_EMPTY;
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      act_q <= BANK_EMPTY;
      cnt_q <= '0;
`ifdef RESHAPE_SER_PINGPONG_EN
      shd_q <= BANK_EMPTY;
      sel_q <= 1'b0;
      s_ready_q <= 1'b1;
`endif
    end else begin
      act_q <= act_d;
      cnt_q <= cnt_d;
`ifdef RESHAPE_SER_PINGPONG_EN
      shd_q <= shd_d;
      sel_q <= sel_d;
      s_ready_q <= s_ready_d;
`endif
    end
endmodule

// File: tb/tb_reshape_serializer.sv
// tb_reshape_serializer: scoreboard and table-driven checks for reshape_serializer.
module tb_reshape_serializer;
  localparam int W = 16;
  localparam int N = 40;
  typedef struct {logic [W-1:0] d; logic l;} exp_t;
  typedef struct {int base; int step; bit bp; int cycles;} vec_t;
  logic clk = 0, reset_n = 0;
  logic [N-1:0][W-1:0] din = '0, din4 = '0;
  logic s_valid = 0, s_ready, m_valid, m_ready = 1, m_last;
  logic [0:0][W-1:0] dout;
  logic s_valid4 = 0, s_ready4, m_valid4, m_ready4 = 1, m_last4;
  logic [3:0][W-1:0] dout4;
  exp_t q[$];
  int n_vec = 0, n_err = 0;
  bit cont_chk = 0;
  logic [W-1:0] acc_out;
  logic acc_last;

  always #5 clk = ~clk;

  reshape_serializer dut (
    .clk(clk), .reset_n(reset_n), .in(din), .s_valid(s_valid), .s_ready(s_ready),
    .out(dout), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );
  reshape_serializer #(.DATA_W(W), .N_IN(N), .LANES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in(din4), .s_valid(s_valid4), .s_ready(s_ready4),
    .out(dout4), .m_valid(m_valid4), .m_ready(m_ready4), .m_last(m_last4)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Offer a frame until accepted; expected beats enter the scoreboard on acceptance.
  task automatic send(input int base, input int step);
    bit acc = 0;
    for (int i = 0; i < N; i++) din[i] = W'(base + step * i);
    s_valid = 1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1;
        acc_out = dout[0];
        acc_last = m_last;
        for (int i = 0; i < N; i++) q.push_back('{d: W'(base + step * i), l: (i == N - 1)});
      end
      @(posedge clk); #1;
    end
    s_valid = 0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no s_ready expected acceptance");
    end
  endtask

  task automatic drain(input bit bp, input int nlast, input int exp_cyc, input string name);
    int c = 0;
    int seen = 0;
    while (seen < nlast && c < 400) begin
      m_ready = bp ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (m_valid && m_ready && m_last) seen++;
      c++;
      if (seen == nlast) cont_chk = 0;
      @(posedge clk); #1;
    end
    m_ready = 1;
    check(name, c, exp_cyc);
  endtask

  task automatic run_frame(input vec_t v);
    check("idle_valid", m_valid, 0);
    send(v.base, v.step);
    check("latency_valid", m_valid, 1);
    drain(v.bp, 1, v.cycles, "frame_cycles");
  endtask

  initial begin : monitor
    exp_t e;
    bit prev_stall = 0;
    logic [W-1:0] prev_out = '0;
    logic prev_last = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev_stall = 0;
      else begin
        if (m_last && !m_valid) begin
          n_vec++; n_err++;
          $display("FAIL last_without_valid: got m_last=1 expected 0");
        end
        if (prev_stall) begin
          check("hold_out", dout[0], prev_out);
          check("hold_last", m_last, prev_last);
        end
        if (cont_chk) check("no_bubble", m_valid, 1);
        if (m_valid && m_ready) begin
          if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL extra_beat: got %0h expected no beat", dout[0]);
          end else begin
            e = q.pop_front();
            check("beat_data", dout[0], e.d);
            check("beat_last", m_last, e.l);
          end
        end
        prev_stall = m_valid & !m_ready;
        prev_out = dout[0];
        prev_last = m_last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    vec_t v;
    logic [3:0][W-1:0] e4;
    bit found;
    tbl = '{'{0, 3, 0, 40}, '{0, 3, 1, 79}, '{7, 5, 1, 79}, '{1000, 1, 0, 40}};
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_out", dout[0], 0);
    check("rst4_m_valid", m_valid4, 0);
    check("rst4_s_ready", s_ready4, 1);
    check("rst4_out", dout4, 0);
    @(posedge clk); #1;
    reset_n = 1;
    for (int t = 0; t < 4; t++) run_frame(tbl[t]);
    // Four lanes: ten beats of consecutive words.
    for (int i = 0; i < N; i++) din4[i] = W'(i);
    s_valid4 = 1;
    @(negedge clk);
    check("l4_s_ready", s_ready4, 1);
    @(posedge clk); #1;
    s_valid4 = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) e4[k] = W'(4 * b + k);
      @(negedge clk);
      check("l4_valid", m_valid4, 1);
      check("l4_beat", dout4, e4);
      check("l4_last", m_last4, b == 9);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("l4_done", m_valid4, 0);
    @(posedge clk); #1;
`ifdef RESHAPE_SER_PINGPONG_EN
    send(0, 1);
    cont_chk = 1;
    repeat (5) begin @(posedge clk); #1; end
    send(200, 1);
    check("pp_b_during_a5", acc_out, 5);
    check("pp_s_ready_drop", s_ready, 0);
    send(400, 1);
    check("pp_c_at_b0", acc_out, 200);
    drain(0, 2, 79, "pp_cycles");
`else
    send(0, 1);
    cont_chk = 1;
    send(500, 1);
    check("b2b_accept_on_last", acc_last, 1);
    check("b2b_accept_out", acc_out, 39);
    drain(0, 1, 40, "b2b_cycles");
`endif
    // Reset in the middle of beat 17.
    send(0, 3);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (dout[0] == W'(51)) found = 1;
    end
    check("rst_reach_beat17", found, 1);
    #2 reset_n = 0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_last", m_last, 0);
    check("mid_rst_s_ready", s_ready, 1);
    check("mid_rst_out", dout[0], 0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1;
    v = '{100, 1, 0, 40};
    run_frame(v);
    check("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
